mmcm_drp_reconfig: RTL and testbench
====================================

Name: mmcm_drp_reconfig

Overview:
- Run-time reconfiguration sequencer for a 7-series MMCM (MMCME2_ADV DRP port); switches the audio/core clock tree between NUM_CONFIGS precomputed frequency plans without re-bitstreaming.
- On request: holds the MMCM in reset, performs read-modify-write on a parametrised list of DRP registers, releases reset and waits for LOCKED, reporting done or error.
- Sits beside the clock primitive in the clocking top; MMCM DCLK is driven from clk.

Parameters:
- NUM_CONFIGS, 2, number of selectable clock plans.
- NUM_WRITES, 23, DRP register entries per plan.
- CFG_ROM, all zeros, packed table of NUM_CONFIGS*NUM_WRITES entries, 39 bits each: {addr[6:0], mask[15:0], data[15:0]}; entry index = cfg*NUM_WRITES + n.
- RST_CYCLES, 4, cycles mmcm_rst is held before the first DRP access.
- DRDY_TIMEOUT, 64, max cycles from den to drdy.
- LOCK_TIMEOUT, 65536, max cycles from mmcm_rst release to locked.

Ports:
- clk  in  1  system clock, also MMCM DCLK.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- cfg_sel  in  clog2(NUM_CONFIGS) (min 1)  plan index, latched with start.
- busy  out  1  high from the cycle after an accepted start until DONE/ERR exits.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  sticky; set on failure, cleared by the next accepted start or reset.
- mmcm_rst  out  1  drives MMCM RST.
- daddr  out  7  DRP address.
- di  out  16  DRP write data.
- den  out  1  DRP enable, single-cycle pulse.
- dwe  out  1  DRP write enable, high only with den on writes.
- do_i  in  16  DRP read data.
- drdy  in  1  DRP ready.
- locked  in  1  MMCM LOCKED, asynchronous; double-flop synchronised internally.

Behaviour:
- Reset: busy=0, done=0, error=0, mmcm_rst=0, den=0, dwe=0, daddr=0, di=0; FSM to IDLE; counters cleared.
- States: IDLE, BAD_SEL, ASSERT_RST, READ, WAIT_RD, WRITE, WAIT_WR, RELEASE, WAIT_LOCK, DONE, ERR.
- IDLE: start=1 latches cfg_sel, clears error, n=0. If cfg_sel >= NUM_CONFIGS -> BAD_SEL (no DRP access, mmcm_rst untouched) -> ERR; else -> ASSERT_RST.
- ASSERT_RST: mmcm_rst=1; stays RST_CYCLES cycles -> READ.
- READ: den=1, dwe=0, daddr=entry.addr for exactly one cycle -> WAIT_RD.
- WAIT_RD: on drdy, capture new = (do_i & entry.mask) | (entry.data & ~entry.mask) -> WRITE. Mask bits set = bits preserved.
- WRITE: den=1, dwe=1, daddr=entry.addr, di=new for one cycle -> WAIT_WR.
- WAIT_WR: on drdy, n==NUM_WRITES-1 -> RELEASE, else n++ -> READ.
- Timeout: wait counter starts at 0 in the cycle after den; if drdy is not seen within DRDY_TIMEOUT cycles -> ERR.
- RELEASE: mmcm_rst=0 -> WAIT_LOCK.
- WAIT_LOCK: synchronised locked=1 -> DONE; LOCK_TIMEOUT cycles elapsed -> ERR.
- DONE: done=1 one cycle -> IDLE.
- ERR: error=1, mmcm_rst=0 one cycle -> IDLE; error stays set.
- drdy while not in WAIT_RD/WAIT_WR is ignored, including a late drdy after a timeout.
- start while busy is ignored; no queuing.
- Reset mid-sequence aborts at once: mmcm_rst drops to 0. Register contents left in the MMCM are undefined, and a new start is required.
- Minimum latency, DRP response in 1 cycle, lock immediate: 1 + RST_CYCLES + 4*NUM_WRITES + ~5 cycles from start to done.

Decomposition:
- Package mmcm_drp_pkg:
  - state enum;
  - entry field widths and offsets (ADDR_W=7, DATA_W=16, ENTRY_W=39);
  - function drp_entry(addr, mask, data) returning a 39-bit entry for building CFG_ROM;
  - MMCM register address constants (CLKOUT0_REG1=7'h08, CLKFBOUT_REG1=7'h14, DIVCLK=7'h16, LOCK_REG1..3=7'h18-1A, FILT_REG1..2=7'h4E-4F).
- One sub-module, drp_rmw_port: performs one read-modify-write with timeout, handshake start/done/timeout. The top FSM sequences entries and handles reset/lock.

Test Plan:
- Nominal: NUM_WRITES=2, cfg 1 entries {08,1000,00C3},{14,1000,0145}; DRP model returns 3-cycle drdy with do=FFFF; locked rises 100 cycles after release -> writes 08<=10C3, 14<=1145, mmcm_rst high across all DRP accesses, single done pulse, error=0.
- Bad select: NUM_CONFIGS=2, start with cfg_sel=3 -> error=1, zero den pulses, mmcm_rst never asserted.
- DRDY timeout: model never answers the first read, DRDY_TIMEOUT=16 -> ERR 17 cycles after den, mmcm_rst=0, no done; later stray drdy ignored.
- Lock timeout: locked held 0, LOCK_TIMEOUT=200 -> error=1 after 200 cycles in WAIT_LOCK; a subsequent good start clears error and completes.
- Start while busy: second start mid-WAIT_RD with different cfg_sel -> ignored, exactly 2*NUM_WRITES den pulses with the original plan.
- Reset mid-WRITE: reset asserted during WAIT_WR -> next cycle all outputs at reset values, late drdy ignored, fresh start runs the full sequence.

Source files
------------

// File: rtl/mmcm_drp_pkg.sv
// mmcm_drp_pkg: shared types and constants for the MMCM DRP
// reconfiguration sequencer and its CFG_ROM table builder.
package mmcm_drp_pkg;

    localparam int ADDR_W  = 7;
    localparam int DATA_W  = 16;
    localparam int ENTRY_W = ADDR_W + 2 * DATA_W;

    localparam logic [ADDR_W-1:0] CLKOUT0_REG1  = 7'h08;
    localparam logic [ADDR_W-1:0] CLKFBOUT_REG1 = 7'h14;
    localparam logic [ADDR_W-1:0] DIVCLK        = 7'h16;
    localparam logic [ADDR_W-1:0] LOCK_REG1     = 7'h18;
    localparam logic [ADDR_W-1:0] LOCK_REG2     = 7'h19;
    localparam logic [ADDR_W-1:0] LOCK_REG3     = 7'h1A;
    localparam logic [ADDR_W-1:0] FILT_REG1     = 7'h4E;
    localparam logic [ADDR_W-1:0] FILT_REG2     = 7'h4F;

    typedef enum logic [3:0] {
        IDLE, BAD_SEL, ASSERT_RST, READ, WAIT_RD,
        WRITE, WAIT_WR, RELEASE, WAIT_LOCK, DONE, ERR
    } state_t;

    // Mask bits set = bits preserved from the MMCM read value.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] mask;
        logic [DATA_W-1:0] data;
    } drp_entry_t;

    function automatic logic [ENTRY_W-1:0] drp_entry(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] mask,
        input logic [DATA_W-1:0] data
    );
        return {addr, mask, data};
    endfunction

endpackage

// File: rtl/mmcm_drp_reconfig_port.sv
// drp_rmw_port: DRP side of one read-modify-write. The sequencer
// raises rd_req/wr_req for the access cycle and rd_wait/wr_wait
// while waiting; ack reports drdy, timeout reports a missing drdy.
// Ports: clk, reset, phase strobes, entry, DRP bus, ack, timeout.
module drp_rmw_port
    import mmcm_drp_pkg::*;
#(
    parameter int DRDY_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_req,
    input  logic              wr_req,
    input  logic              rd_wait,
    input  logic              wr_wait,
    input  drp_entry_t        entry,
    input  logic [DATA_W-1:0] do_i,
    input  logic              drdy,
    output logic [ADDR_W-1:0] daddr,
    output logic [DATA_W-1:0] di,
    output logic              den,
    output logic              dwe,
    output logic              ack,
    output logic              timeout
);

    localparam int DW = $clog2(DRDY_TIMEOUT + 1);
    localparam logic [DW-1:0] D_LAST = DW'(DRDY_TIMEOUT - 1);

    logic [DW-1:0]     cnt;
    logic [DATA_W-1:0] new_q;
    logic              waiting;

    assign waiting = rd_wait | wr_wait;

    // cnt is 0 in the first wait cycle after den.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            new_q <= '0;
        end else begin
            cnt <= waiting ? cnt + 1'b1 : '0;
            if (rd_wait && drdy)
                new_q <= (do_i & entry.mask)
                       | (entry.data & ~entry.mask);
        end
    end

    assign den     = rd_req | wr_req;
    assign dwe     = wr_req;
    assign daddr   = den ? entry.addr : '0;
    assign di      = wr_req ? new_q : '0;
    assign ack     = waiting & drdy;
    assign timeout = waiting & ~drdy & (cnt == D_LAST);

endmodule

// File: rtl/mmcm_drp_reconfig.sv
// mmcm_drp_reconfig: switches an MMCME2_ADV between clock plans by
// holding it in reset, rewriting DRP registers and awaiting LOCKED.
// Ports: clk/reset, start/cfg_sel request, busy/done/error status,
// mmcm_rst, DRP bus (daddr, di, den, dwe, do_i, drdy), locked.
module mmcm_drp_reconfig
    import mmcm_drp_pkg::*;
#(
    parameter int NUM_CONFIGS  = 2,
    parameter int NUM_WRITES   = 23,
    parameter logic [NUM_CONFIGS*NUM_WRITES*ENTRY_W-1:0]
                  CFG_ROM      = '0,
    parameter int RST_CYCLES   = 4,
    parameter int DRDY_TIMEOUT = 64,
    parameter int LOCK_TIMEOUT = 65536,
    localparam int SEL_W =
        (NUM_CONFIGS > 1) ? $clog2(NUM_CONFIGS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [SEL_W-1:0]  cfg_sel,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              mmcm_rst,
    output logic [ADDR_W-1:0] daddr,
    output logic [DATA_W-1:0] di,
    output logic              den,
    output logic              dwe,
    input  logic [DATA_W-1:0] do_i,
    input  logic              drdy,
    input  logic              locked
);

    localparam int NW_W =
        (NUM_WRITES > 1) ? $clog2(NUM_WRITES) : 1;
    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam int LW = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [NW_W-1:0] N_LAST = NW_W'(NUM_WRITES - 1);
    localparam logic [RW-1:0]   R_LAST = RW'(RST_CYCLES - 1);
    localparam logic [LW-1:0]   L_LAST = LW'(LOCK_TIMEOUT - 1);

    state_t            state, state_n;
    logic [SEL_W-1:0]  cfg_q;
    logic [NW_W-1:0]   n;
    logic [RW-1:0]     rcnt;
    logic [LW-1:0]     lcnt;
    logic              err_q;
    logic              lk_m, lk_s;
    logic              bad_sel;
    int unsigned       idx;
    drp_entry_t        entry;
    logic              ack, timeout;

    assign bad_sel = 32'(cfg_sel) >= 32'(NUM_CONFIGS);
    assign idx     = 32'(cfg_q) * 32'(NUM_WRITES) + 32'(n);
    assign entry   = ENTRY_W'(CFG_ROM >> (idx * ENTRY_W));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cfg_q <= '0;
            n     <= '0;
            rcnt  <= '0;
            lcnt  <= '0;
            err_q <= 1'b0;
            lk_m  <= 1'b0;
            lk_s  <= 1'b0;
        end else begin
            state <= state_n;
            lk_m  <= locked;
            lk_s  <= lk_m;
            if (state == IDLE && start) begin
                cfg_q <= cfg_sel;
                n     <= '0;
                err_q <= 1'b0;
            end
            // Set on entry so error is already high in ERR.
            if (state_n == ERR)
                err_q <= 1'b1;
            rcnt <= (state == ASSERT_RST) ? rcnt + 1'b1 : '0;
            lcnt <= (state == WAIT_LOCK) ? lcnt + 1'b1 : '0;
            if (state == WAIT_WR && ack && n != N_LAST)
                n <= n + 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:
                if (start)
                    state_n = bad_sel ? BAD_SEL : ASSERT_RST;
            BAD_SEL:
                state_n = ERR;
            ASSERT_RST:
                if (rcnt == R_LAST)
                    state_n = READ;
            READ:
                state_n = WAIT_RD;
            WAIT_RD:
                if (ack)
                    state_n = WRITE;
                else if (timeout)
                    state_n = ERR;
            WRITE:
                state_n = WAIT_WR;
            WAIT_WR:
                if (ack)
                    state_n = (n == N_LAST) ? RELEASE : READ;
                else if (timeout)
                    state_n = ERR;
            RELEASE:
                state_n = WAIT_LOCK;
            WAIT_LOCK:
                if (lk_s)
                    state_n = DONE;
                else if (lcnt == L_LAST)
                    state_n = ERR;
            DONE, ERR:
                state_n = IDLE;
            default:
                state_n = IDLE;
        endcase
    end

    assign busy     = state != IDLE;
    assign done     = state == DONE;
    assign error    = err_q;
    assign mmcm_rst = state inside {ASSERT_RST, READ, WAIT_RD,
                                    WRITE, WAIT_WR};

    drp_rmw_port #(
        .DRDY_TIMEOUT(DRDY_TIMEOUT)
    ) u_port (
        .clk     (clk),
        .reset   (reset),
        .rd_req  (state == READ),
        .wr_req  (state == WRITE),
        .rd_wait (state == WAIT_RD),
        .wr_wait (state == WAIT_WR),
        .entry   (entry),
        .do_i    (do_i),
        .drdy    (drdy),
        .daddr   (daddr),
        .di      (di),
        .den     (den),
        .dwe     (dwe),
        .ack     (ack),
        .timeout (timeout)
    );

endmodule

// File: tb/tb_mmcm_drp_reconfig.sv
// tb_mmcm_drp_reconfig: randomized bench for mmcm_drp_reconfig with
// a DRP register-file model, an MMCM lock model and a plan scoreboard.
module tb_mmcm_drp_reconfig;
    import mmcm_drp_pkg::*;

    localparam int NC   = 3;
    localparam int NW   = 2;
    localparam int RSTC = 4;
    localparam int DTO  = 16;
    localparam int LTO  = 200;
    localparam int LIM  = 3000;

    localparam logic [6:0] T_ADDR [NC*NW] = '{
        7'h16, 7'h18, 7'h08, 7'h14, 7'h4E, 7'h4F};
    localparam logic [15:0] T_MASK [NC*NW] = '{
        16'hFF00, 16'h00FF, 16'h1000, 16'h1000,
        16'h0F0F, 16'h0000};
    localparam logic [15:0] T_DATA [NC*NW] = '{
        16'h1234, 16'hABCD, 16'h00C3, 16'h0145,
        16'h5A5A, 16'hBEEF};

    localparam logic [NC*NW*ENTRY_W-1:0] ROM = {
        drp_entry(FILT_REG2,     16'h0000, 16'hBEEF),
        drp_entry(FILT_REG1,     16'h0F0F, 16'h5A5A),
        drp_entry(CLKFBOUT_REG1, 16'h1000, 16'h0145),
        drp_entry(CLKOUT0_REG1,  16'h1000, 16'h00C3),
        drp_entry(LOCK_REG1,     16'h00FF, 16'hABCD),
        drp_entry(DIVCLK,        16'hFF00, 16'h1234)};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  cfg_sel = '0;
    logic        busy, done, error, mmcm_rst;
    logic [6:0]  daddr;
    logic [15:0] di;
    logic        den, dwe;
    logic [15:0] do_i = '0;
    logic        drdy = 1'b0;
    logic        locked = 1'b0;

    mmcm_drp_reconfig #(
        .NUM_CONFIGS (NC),
        .NUM_WRITES  (NW),
        .CFG_ROM     (ROM),
        .RST_CYCLES  (RSTC),
        .DRDY_TIMEOUT(DTO),
        .LOCK_TIMEOUT(LTO)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .cfg_sel (cfg_sel),
        .busy    (busy),
        .done    (done),
        .error   (error),
        .mmcm_rst(mmcm_rst),
        .daddr   (daddr),
        .di      (di),
        .den     (den),
        .dwe     (dwe),
        .do_i    (do_i),
        .drdy    (drdy),
        .locked  (locked)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] mem [128];
    logic [6:0]  wq_a [$];
    logic [15:0] wq_d [$];
    logic [6:0]  exp_a [$];
    logic [15:0] exp_d [$];

    int cyc = 0, busy_cyc, den_cnt, done_cnt, den_norst, bad_dwe;
    int rst_lead, rst_rise, rst_fall_cyc, err_rise_cyc;
    int first_den_cyc;
    logic rst_prev = 1'b0, err_prev = 1'b0, rst_at_err, err_first;
    int lat = 1, cd = 0, lock_delay = 0, low_cnt = 0;
    bit pend = 0, pend_we = 0, drop_next = 0, stray = 0;
    bit lock_en = 1;
    logic [6:0] pend_addr = '0;

    task automatic check(input string tag, input int got,
                         input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h",
                     tag, got, exp);
        end
    endtask

    // One cycle of monitors plus the DRP and MMCM lock models.
    task automatic step();
        cyc++;
        if (busy) busy_cyc++;
        if (mmcm_rst && den_cnt == 0 && !den) rst_lead++;
        if (mmcm_rst && !rst_prev) rst_rise++;
        if (!mmcm_rst && rst_prev) rst_fall_cyc = cyc;
        if (error && !err_prev) begin
            err_rise_cyc = cyc;
            rst_at_err = mmcm_rst;
        end
        if (done) done_cnt++;
        if (dwe && !den) bad_dwe++;
        if (den && !mmcm_rst) den_norst++;
        if (den && den_cnt == 0) first_den_cyc = cyc;
        if (den) den_cnt++;
        rst_prev = mmcm_rst;
        err_prev = error;
        drdy = stray;
        stray = 0;
        do_i = 16'($urandom);
        if (pend) begin
            cd--;
            if (cd == 0) begin
                pend = 0;
                drdy = 1'b1;
                if (!pend_we) do_i = mem[pend_addr];
            end
        end
        if (den) begin
            if (dwe) begin
                mem[daddr] = di;
                wq_a.push_back(daddr);
                wq_d.push_back(di);
            end
            if (drop_next) drop_next = 0;
            else begin
                pend = 1;
                cd = lat;
                pend_we = dwe;
                pend_addr = daddr;
            end
        end
        if (mmcm_rst) low_cnt = 0;
        else low_cnt++;
        locked = lock_en && !mmcm_rst && low_cnt > lock_delay;
    endtask

    task automatic idle(input int cycles);
        busy_cyc = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            step();
        end
    endtask

    task automatic plan(input int cfg);
        logic [15:0] sh [128];
        sh = mem;
        exp_a.delete();
        exp_d.delete();
        for (int k = 0; k < NW; k++) begin
            int i;
            logic [15:0] v;
            i = cfg * NW + k;
            v = (sh[T_ADDR[i]] & T_MASK[i])
              | (T_DATA[i] & ~T_MASK[i]);
            sh[T_ADDR[i]] = v;
            exp_a.push_back(T_ADDR[i]);
            exp_d.push_back(v);
        end
    endtask

    // mode 0: plain, 1: second start in WAIT_RD,
    // 2: reset pulse in WAIT_WR.
    task automatic run(input int cfg, input int lt, input int lk,
                       input bit lk_en, input int mode);
        int t, ph;
        bit arm, poked;
        busy_cyc = 0; den_cnt = 0; done_cnt = 0;
        den_norst = 0; bad_dwe = 0; rst_lead = 0; rst_rise = 0;
        rst_fall_cyc = -1; err_rise_cyc = -1; first_den_cyc = -1;
        wq_a.delete();
        wq_d.delete();
        lat = lt;
        lock_delay = lk;
        lock_en = lk_en;
        cfg_sel = 2'(cfg);
        start = 1'b1;
        t = 0; ph = 0; arm = 0; poked = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            step();
            t++;
            if (t == 1) err_first = error;
            if (mode == 1 && den_cnt > 0 && !poked) begin
                if (arm) begin
                    start = 1'b1;
                    cfg_sel = 2'((cfg + 1) % NC);
                    poked = 1;
                end
                arm = 1;
            end
            if (mode == 2) begin
                if (ph == 2) begin
                    reset = 1'b0;
                    check("rst_outs", 32'({busy, done, error,
                          mmcm_rst, den, dwe, daddr, di}), 0);
                    ph = 3;
                end else if (ph == 1) begin
                    reset = 1'b1;
                    ph = 2;
                end else if (ph == 0 && wq_a.size() > 0) begin
                    ph = 1;
                end
            end
        end while ((busy || ph == 2) && t < LIM);
        check("bounded", 32'(t < LIM), 1);
        if (t >= LIM) begin
            reset = 1'b1;
            idle(2);
            reset = 1'b0;
        end
    endtask

    task automatic check_good(input string tg);
        check({tg, "_done"}, done_cnt, 1);
        check({tg, "_err"}, 32'(error), 0);
        check({tg, "_den"}, den_cnt, 2 * NW);
        check({tg, "_norst"}, den_norst, 0);
        check({tg, "_dwe"}, bad_dwe, 0);
        check({tg, "_lead"}, rst_lead, RSTC);
        check({tg, "_rise"}, rst_rise, 1);
        check({tg, "_rstend"}, 32'(mmcm_rst), 0);
        check({tg, "_nwr"}, wq_a.size(), NW);
        for (int k = 0; k < NW; k++) begin
            if (k < wq_a.size()) begin
                check($sformatf("%s_a%0d", tg, k),
                      32'(wq_a[k]), 32'(exp_a[k]));
                check($sformatf("%s_d%0d", tg, k),
                      32'(wq_d[k]), 32'(exp_d[k]));
            end
        end
    endtask

    task automatic rand_mem();
        for (int i = 0; i < NC * NW; i++)
            mem[T_ADDR[i]] = 16'($urandom);
    endtask

    initial begin
        int d0, c;
        for (int i = 0; i < 128; i++) mem[i] = 16'($urandom);
        idle(3);
        check("rst_ctl", 32'({busy, done, error, mmcm_rst,
                              den, dwe}), 0);
        check("rst_daddr", 32'(daddr), 0);
        check("rst_di", 32'(di), 0);
        reset = 1'b0;
        idle(3);

        mem[7'h08] = 16'hFFFF;
        mem[7'h14] = 16'hFFFF;
        plan(1);
        run(1, 3, 100, 1, 0);
        check_good("nom");
        if (wq_d.size() == 2) begin
            check("nom_v0", 32'(wq_d[0]), 32'h10C3);
            check("nom_v1", 32'(wq_d[1]), 32'h1145);
        end
        idle(4);

        run(3, 1, 0, 1, 0);
        check("bad_err", 32'(error), 1);
        check("bad_den", den_cnt, 0);
        check("bad_rst", rst_rise, 0);
        check("bad_done", done_cnt, 0);
        check("bad_busy", busy_cyc, 2);
        idle(4);

        drop_next = 1;
        run(0, 2, 0, 1, 0);
        check("dto_err", 32'(error), 1);
        check("dto_lat", err_rise_cyc - first_den_cyc, DTO + 1);
        check("dto_rst", 32'(rst_at_err), 0);
        check("dto_done", done_cnt, 0);
        check("dto_den", den_cnt, 1);
        d0 = den_cnt;
        stray = 1;
        idle(10);
        check("stray_busy", busy_cyc, 0);
        check("stray_den", den_cnt, d0);
        check("stray_err", 32'(error), 1);

        rand_mem();
        run(2, 2, 0, 0, 0);
        check("lto_err", 32'(error), 1);
        check("lto_done", done_cnt, 0);
        check("lto_lat", err_rise_cyc - rst_fall_cyc, LTO + 1);
        check("lto_den", den_cnt, 2 * NW);
        idle(4);
        c = $urandom_range(0, NC - 1);
        plan(c);
        run(c, 2, 7, 1, 0);
        check("reerr_clr", 32'(err_first), 0);
        check_good("after_lto");
        idle(4);

        rand_mem();
        plan(0);
        run(0, 3, 10, 1, 1);
        check_good("poke");
        idle(4);

        run(1, 4, 5, 1, 2);
        d0 = den_cnt;
        idle(10);
        check("late_busy", busy_cyc, 0);
        check("late_den", den_cnt, d0);
        rand_mem();
        plan(1);
        run(1, 2, 5, 1, 0);
        check_good("post_rst");
        idle(3);

        for (int r = 0; r < 6; r++) begin
            rand_mem();
            c = $urandom_range(0, NC - 1);
            plan(c);
            run(c, $urandom_range(1, 6), $urandom_range(0, 40),
                1, 0);
            check_good($sformatf("rnd%0d", r));
            idle($urandom_range(1, 5));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
